id_stage_regs: RTL

- Instruction-decode stage that consumes the IF/ID latch outputs (PC, instruction).
- Contains the 32x32 register file with a write-back port, the main decoder and load-use hazard detection.
- Registers the ID/EX pipeline latch.
- Drives stall_o back to the PC and the IF/ID latch so the fetch side holds on a load-use hazard.

---
 rtl/id_stage_regs.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage_regs.sv
// Purpose : instruction-decode stage: register file, main decoder, load-use
//           hazard detect and the ID/EX pipeline latch.
// Latency : one cycle from the IF/ID latch inputs to the ex_* outputs.
// Backpressure: stall_o (combinational) holds PC and IF/ID on a load-use
//           hazard; the latch takes a bubble that cycle, so a stall lasts
//           exactly one cycle.
//
// Optional feature: define ID_ILLEGAL_OP_EN to add ex_illegal_o, which flags
// an opcode outside the decoded set.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-low reset
//   pc_i, instr_i             PC and instruction from the IF/ID latch
//   flush_i                   squash the instruction in ID (branch taken in EX)
//   wb_we_i/addr_i/data_i     register-file write-back port
//   stall_o                   hold PC and IF/ID this cycle
//   ex_*                      registered ID/EX latch: PC, operands, immediate,
//                             register indices and control bits
//   ex_illegal_o              (ID_ILLEGAL_OP_EN only) unknown opcode latched

module id_stage_regs #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [31:0]     instr_i,
   input  logic            flush_i,
   input  logic            wb_we_i,
   input  logic [4:0]      wb_addr_i,
   input  logic [XLEN-1:0] wb_data_i,
   output logic            stall_o,
   output logic [XLEN-1:0] ex_pc_o,
   output logic [XLEN-1:0] ex_rs_data_o,
   output logic [XLEN-1:0] ex_rt_data_o,
   output logic [XLEN-1:0] ex_imm_o,
   output logic [4:0]      ex_rs_o,
   output logic [4:0]      ex_rt_o,
   output logic [4:0]      ex_rd_o,
   output logic            ex_reg_write_o,
   output logic            ex_mem_to_reg_o,
   output logic            ex_mem_read_o,
   output logic            ex_mem_write_o,
   output logic            ex_alu_src_o,
   output logic            ex_reg_dst_o,
   output logic            ex_branch_o,
`ifdef ID_ILLEGAL_OP_EN
   output logic            ex_illegal_o,
`endif
   output logic [1:0]      ex_alu_op_o
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic       reg_dst;
      logic       branch;
      logic [1:0] alu_op;
   } ctrl_t;

   // Instruction fields
   logic [5:0]      opcode;
   logic [4:0]      rs;
   logic [4:0]      rt;
   logic [4:0]      rd;
   logic [XLEN-1:0] imm_sext;

   assign opcode   = instr_i[31:26];
   assign rs       = instr_i[25:21];
   assign rt       = instr_i[20:16];
   assign rd       = instr_i[15:11];
   assign imm_sext = {{(XLEN-16){instr_i[15]}}, instr_i[15:0]};

   // ------------------------------------------------------------------
   // Main decoder
   // ------------------------------------------------------------------
   ctrl_t dec_ctrl;
   logic  uses_rt;   // rt is a source operand (not a destination)
`ifdef ID_ILLEGAL_OP_EN
   logic  dec_illegal;
`endif

   always_comb begin
      dec_ctrl = '0;
      uses_rt  = 1'b0;
`ifdef ID_ILLEGAL_OP_EN
      dec_illegal = 1'b0;
`endif
      case (opcode)
         OP_RTYPE: begin
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.reg_dst   = 1'b1;
            dec_ctrl.alu_op    = ALU_FUNCT;
            uses_rt            = 1'b1;
         end
         OP_ADDI: begin
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.alu_src   = 1'b1;
            dec_ctrl.alu_op    = ALU_ADD;
         end
         OP_LW: begin
            dec_ctrl.reg_write  = 1'b1;
            dec_ctrl.mem_to_reg = 1'b1;
            dec_ctrl.mem_read   = 1'b1;
            dec_ctrl.alu_src    = 1'b1;
            dec_ctrl.alu_op     = ALU_ADD;
         end
         OP_SW: begin
            dec_ctrl.mem_write = 1'b1;
            dec_ctrl.alu_src   = 1'b1;
            dec_ctrl.alu_op    = ALU_ADD;
            uses_rt            = 1'b1;
         end
         OP_BEQ: begin
            dec_ctrl.branch = 1'b1;
            dec_ctrl.alu_op = ALU_SUB;
            uses_rt         = 1'b1;
         end
         default: begin
`ifdef ID_ILLEGAL_OP_EN
            dec_illegal = 1'b1;
`endif
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Register file: combinational reads, posedge write, r0 hardwired 0
   // ------------------------------------------------------------------
   logic [XLEN-1:0] rf [NREG];
   logic [XLEN-1:0] rs_data;
   logic [XLEN-1:0] rt_data;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int i = 0; i < NREG; i++) begin
            rf[i] <= '0;
         end
      end else if (wb_we_i && (wb_addr_i != 5'd0)) begin
         rf[wb_addr_i] <= wb_data_i;
      end
   end

   // A write-back landing this cycle is forwarded so ID sees the new value
   // without waiting for the register update.
   always_comb begin
      rs_data = '0;
      if (rs != 5'd0) begin
         if (wb_we_i && (wb_addr_i == rs)) begin
            rs_data = wb_data_i;
         end else begin
            rs_data = rf[rs];
         end
      end
   end

   always_comb begin
      rt_data = '0;
      if (rt != 5'd0) begin
         if (wb_we_i && (wb_addr_i == rt)) begin
            rt_data = wb_data_i;
         end else begin
            rt_data = rf[rt];
         end
      end
   end

   // ------------------------------------------------------------------
   // Load-use hazard: a load in EX whose destination feeds this instruction.
   // rt only counts when the instruction actually reads it; for addi/lw it
   // is the destination.
   // ------------------------------------------------------------------
   assign stall_o = ex_mem_read_o && (ex_rt_o != 5'd0) &&
                    ((ex_rt_o == rs) || (uses_rt && (ex_rt_o == rt)));

   // ------------------------------------------------------------------
   // ID/EX latch. Reset, flush and stall all load an all-zero bubble;
   // flush beats stall, which is why a coinciding pair yields one bubble.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_i || flush_i || stall_o) begin
         ex_pc_o         <= '0;
         ex_rs_data_o    <= '0;
         ex_rt_data_o    <= '0;
         ex_imm_o        <= '0;
         ex_rs_o         <= '0;
         ex_rt_o         <= '0;
         ex_rd_o         <= '0;
         ex_reg_write_o  <= 1'b0;
         ex_mem_to_reg_o <= 1'b0;
         ex_mem_read_o   <= 1'b0;
         ex_mem_write_o  <= 1'b0;
         ex_alu_src_o    <= 1'b0;
         ex_reg_dst_o    <= 1'b0;
         ex_branch_o     <= 1'b0;
         ex_alu_op_o     <= 2'b00;
`ifdef ID_ILLEGAL_OP_EN
         ex_illegal_o    <= 1'b0;
`endif
      end else begin
         ex_pc_o         <= pc_i;
         ex_rs_data_o    <= rs_data;
         ex_rt_data_o    <= rt_data;
         ex_imm_o        <= imm_sext;
         ex_rs_o         <= rs;
         ex_rt_o         <= rt;
         ex_rd_o         <= rd;
         ex_reg_write_o  <= dec_ctrl.reg_write;
         ex_mem_to_reg_o <= dec_ctrl.mem_to_reg;
         ex_mem_read_o   <= dec_ctrl.mem_read;
         ex_mem_write_o  <= dec_ctrl.mem_write;
         ex_alu_src_o    <= dec_ctrl.alu_src;
         ex_reg_dst_o    <= dec_ctrl.reg_dst;
         ex_branch_o     <= dec_ctrl.branch;
         ex_alu_op_o     <= dec_ctrl.alu_op;
`ifdef ID_ILLEGAL_OP_EN
         ex_illegal_o    <= dec_illegal;
`endif
      end
   end

endmodule
